// File: rtl/fpa_controller.sv
// fpa_controller: sequencing FSM for the 1s/4e/3m minifloat adder datapath.
// Build macro FPA_CTRL_CYCLE_CNT_EN adds the per-operation cycle counter reported on cyc_cnt.
module fpa_controller #(
    parameter int unsigned MANT_W         = 5,
    parameter int unsigned STEP_W         = 3,
    parameter int unsigned MAX_NORM_STEPS = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [MANT_W-1:0] mant,
    input  logic              add_except,
    input  logic              norm_except,
    output logic              ready,
    output logic              load_en,
    output logic              add_en,
    output logic              norm_en,
    output logic              norm_load,
    output logic              shift_right,
    output logic              done_en,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        cyc_cnt
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CODE_W = 2;

    localparam logic [CODE_W-1:0] ERR_NONE = 2'b00;
    localparam logic [CODE_W-1:0] ERR_ADD  = 2'b01;
    localparam logic [CODE_W-1:0] ERR_NORM = 2'b10;
    localparam logic [CODE_W-1:0] ERR_TMO  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_ADD_CHK,
        S_NORM_LD,
        S_NORM_CHK,
        S_NORM_SH,
        S_DONE,
        S_EXCEPT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STEP_W-1:0]   r_step;
    logic [STEP_W-1:0]   w_step_nxt;
    logic                r_dir;
    logic                w_dir_nxt;
    logic [CODE_W-1:0]   r_err_code;
    logic [CODE_W-1:0]   w_err_code_nxt;
    logic                w_shift_req;

    logic r_ready, r_load_en, r_add_en, r_norm_en, r_norm_load;
    logic r_shift_right, r_done_en, r_done, r_err;
    logic w_ready_nxt, w_load_en_nxt, w_add_en_nxt, w_norm_en_nxt, w_norm_load_nxt;
    logic w_shift_right_nxt, w_done_en_nxt, w_done_nxt, w_err_nxt;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, sequencing registers and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        w_dir_nxt      = r_dir;
        w_err_code_nxt = r_err_code;
        w_shift_req    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_LOAD;
                    w_err_code_nxt = ERR_NONE;
                    w_step_nxt     = '0;
                end
            end
            S_LOAD:    w_state_nxt = S_ADD;
            S_ADD:     w_state_nxt = S_ADD_CHK;
            S_ADD_CHK: begin
                if (add_except) begin
                    w_state_nxt    = S_EXCEPT;
                    w_err_code_nxt = ERR_ADD;
                end else begin
                    w_state_nxt = S_NORM_LD;
                end
            end
            S_NORM_LD: w_state_nxt = S_NORM_CHK;
            S_NORM_CHK: begin
                // Priority: datapath exception, carry-out, normalised, zero, left shift
                if (norm_except) begin
                    w_state_nxt    = S_EXCEPT;
                    w_err_code_nxt = ERR_NORM;
                end else if (mant[MANT_W-1]) begin
                    w_dir_nxt   = 1'b1;
                    w_shift_req = 1'b1;
                end else if (mant[MANT_W-2]) begin
                    w_state_nxt = S_DONE;
                end else if (mant == '0) begin
                    w_state_nxt    = S_EXCEPT;
                    w_err_code_nxt = ERR_ADD;
                end else begin
                    w_dir_nxt   = 1'b0;
                    w_shift_req = 1'b1;
                end

                if (w_shift_req) begin
                    if (r_step == STEP_W'(MAX_NORM_STEPS)) begin
                        w_state_nxt    = S_EXCEPT;
                        w_err_code_nxt = ERR_TMO;
                    end else begin
                        w_step_nxt  = r_step + STEP_W'(1);
                        w_state_nxt = S_NORM_SH;
                    end
                end
            end
            S_NORM_SH: w_state_nxt = S_NORM_CHK;
            S_DONE:    w_state_nxt = S_IDLE;
            S_EXCEPT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt       = (w_state_nxt == S_IDLE);
        w_load_en_nxt     = (w_state_nxt == S_LOAD);
        w_add_en_nxt      = (w_state_nxt == S_ADD);
        w_norm_en_nxt     = (w_state_nxt == S_NORM_LD) || (w_state_nxt == S_NORM_SH);
        w_norm_load_nxt   = (w_state_nxt == S_NORM_LD);
        w_shift_right_nxt = (w_state_nxt == S_NORM_SH) && w_dir_nxt;
        w_done_en_nxt     = (w_state_nxt == S_DONE);
        w_done_nxt        = (w_state_nxt == S_DONE) || (w_state_nxt == S_EXCEPT);
        w_err_nxt         = (w_state_nxt == S_EXCEPT);
    end

    // Outputs are registered images of the state being entered, so they track r_state exactly
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_step        <= '0;
            r_dir         <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_ready       <= 1'b1;
            r_load_en     <= 1'b0;
            r_add_en      <= 1'b0;
            r_norm_en     <= 1'b0;
            r_norm_load   <= 1'b0;
            r_shift_right <= 1'b0;
            r_done_en     <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_step        <= w_step_nxt;
            r_dir         <= w_dir_nxt;
            r_err_code    <= w_err_code_nxt;
            r_ready       <= w_ready_nxt;
            r_load_en     <= w_load_en_nxt;
            r_add_en      <= w_add_en_nxt;
            r_norm_en     <= w_norm_en_nxt;
            r_norm_load   <= w_norm_load_nxt;
            r_shift_right <= w_shift_right_nxt;
            r_done_en     <= w_done_en_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign ready       = r_ready;
    assign load_en     = r_load_en;
    assign add_en      = r_add_en;
    assign norm_en     = r_norm_en;
    assign norm_load   = r_norm_load;
    assign shift_right = r_shift_right;
    assign done_en     = r_done_en;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;

`ifdef FPA_CTRL_CYCLE_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Counter includes the done cycle itself; the snapshot is taken as that cycle ends
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_cnt     <= '0;
            r_cyc_cnt <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= w_cnt_inc;
            end
            if ((r_state == S_DONE) || (r_state == S_EXCEPT)) begin
                r_cyc_cnt <= w_cnt_inc;
            end
        end
    end

    assign cyc_cnt = r_cyc_cnt;
`else
    assign cyc_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fpa_controller.sv
// tb_fpa_controller: randomized scoreboard bench for fpa_controller with a responding datapath model.
// Expected outcomes come from a closed-form normalisation model; a monitor pops them on every done.
module tb_fpa_controller;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] mant = 5'd0;
    logic       add_except = 1'b0;
    logic       norm_except = 1'b0;
    logic       ready, load_en, add_en, norm_en, norm_load, shift_right;
    logic       done_en, done, err;
    logic [1:0] err_code;
    logic [7:0] cyc_cnt;

`ifdef FPA_CTRL_CYCLE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    fpa_controller dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .mant        (mant),
        .add_except  (add_except),
        .norm_except (norm_except),
        .ready       (ready),
        .load_en     (load_en),
        .add_en      (add_en),
        .norm_en     (norm_en),
        .norm_load   (norm_load),
        .shift_right (shift_right),
        .done_en     (done_en),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .cyc_cnt     (cyc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       err;
        bit [1:0] code;
        int       lat;
        int       n0;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    int   timeouts = 0;
    bit   drv_done = 1'b0;

    // Current transaction as seen by the datapath responder
    bit       cur_stuck = 1'b0;
    logic [4:0] cur_m0 = 5'd0;
    int       cur_ne = 99;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Outcome of one add from the normalisation rules: shifts needed, then exception overrides
    function automatic exp_t predict(input bit ae, input logic [4:0] m0, input bit stuck, input int ne);
        exp_t e;
        int   shifts;
        int   lead;
        bit [1:0] code;
        e.n0 = 0;
        if (ae) begin
            e.err = 1'b1; e.code = 2'b01; e.lat = 4;
            return e;
        end
        lead = -1;
        for (int i = 0; i < 5; i++) if (m0[i]) lead = i;
        if (lead < 0) begin
            shifts = 0; code = 2'b01;
        end else if (lead == 3) begin
            shifts = 0; code = 2'b00;
        end else if (stuck) begin
            shifts = 4; code = 2'b11;
        end else if (lead == 4) begin
            shifts = 1; code = 2'b00;
        end else begin
            shifts = 3 - lead; code = 2'b00;
        end
        if (ne <= shifts) begin
            shifts = ne; code = 2'b10;
        end
        e.lat  = 6 + 2 * shifts;
        e.code = code;
        e.err  = (code != 2'b00);
        return e;
    endfunction

    // Datapath stand-in: normalise register loads/shifts on norm_en, status presented for NORM_CHK
    logic [4:0] mval = 5'd0;
    int         chk = 0;
    always @(negedge clk) begin
        if (norm_en) begin
            if (norm_load) begin
                mval = cur_m0;
                chk  = 0;
            end else begin
                chk++;
                if (!cur_stuck) mval = shift_right ? (mval >> 1) : 5'(mval << 1);
            end
            mant        = mval;
            norm_except = (chk == cur_ne);
        end
    end

    // Monitor: all comparisons happen here
    initial begin : monitor
        exp_t e;
        int   den_cnt;
        int   onehot_viol;
        bit   pend_cyc;
        int   pend_cyc_exp;
        den_cnt = 0; onehot_viol = 0; pend_cyc = 1'b0; pend_cyc_exp = 0;
        forever begin
            @(negedge clk or negedge clr_n);
            if (!clr_n) begin
                #1;
                check("rst_ready", int'(ready), 1);
                check("rst_ctrl", int'({load_en, add_en, norm_en, norm_load, shift_right,
                                        done_en, done, err}), 0);
                check("rst_err_code", int'(err_code), 0);
                check("rst_cyc_cnt", int'(cyc_cnt), 0);
                exp_q.delete();
                pend_cyc = 1'b0;
                den_cnt  = 0;
            end else begin
                if ($countones({load_en, add_en, norm_en, done_en}) > 1) onehot_viol++;
                if (done_en) den_cnt++;
                if (pend_cyc) begin
                    check("cyc_cnt", int'(cyc_cnt), pend_cyc_exp);
                    pend_cyc = 1'b0;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", edge_n - e.n0 + 1, e.lat);
                        check("err", int'(err), int'(e.err));
                        check("err_code", int'(err_code), int'(e.code));
                        check("done_en_pulses", den_cnt, e.err ? 0 : 1);
                        pend_cyc     = 1'b1;
                        pend_cyc_exp = CNT_ON ? e.lat : 0;
                    end
                    den_cnt = 0;
                end
                if (drv_done) begin
                    check("pending_ops", exp_q.size(), 0);
                    check("enable_onehot_violations", onehot_viol, 0);
                    check("wait_timeouts", timeouts, 0);
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $finish;
                end
            end
        end
    end

    task automatic wait_ready(input bit hold, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
            if (!hold) start = ($urandom_range(0, 3) == 0);
        end
    endtask

    // Issue one add; entered and left at a falling edge with ready high
    task automatic run_tx(input bit ae, input logic [4:0] m0, input bit stuck, input int ne,
                          input bit hold);
        exp_t e;
        bit   ok;
        cur_m0     = m0;
        cur_stuck  = stuck;
        cur_ne     = ne;
        add_except = ae;
        start      = 1'b1;
        e = predict(ae, m0, stuck, ne);
        @(posedge clk);
        #1;
        e.n0 = edge_n;
        exp_q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
        wait_ready(hold, ok);
        if (!ok) begin
            timeouts++;
            start = 1'b0;
            clr_n = 1'b0;
            @(negedge clk);
            clr_n = 1'b1;
        end
    endtask

    initial begin : driver
        bit found;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        run_tx(1'b0, 5'b01010, 1'b0, 99, 1'b0);  // already normalised
        run_tx(1'b0, 5'b10110, 1'b0, 99, 1'b0);  // carry out, one right shift
        run_tx(1'b0, 5'b00011, 1'b0, 99, 1'b0);  // two left shifts
        run_tx(1'b1, 5'b01010, 1'b0, 99, 1'b0);  // add exception
        run_tx(1'b0, 5'b00001, 1'b1, 99, 1'b0);  // stuck mantissa -> timeout
        run_tx(1'b0, 5'b00000, 1'b0, 99, 1'b0);  // zero result
        run_tx(1'b0, 5'b10000, 1'b0, 0,  1'b1);  // norm_except beats carry; start held
        run_tx(1'b0, 5'b00100, 1'b0, 1,  1'b1);  // norm_except on second check; start held
        run_tx(1'b0, 5'b01000, 1'b0, 99, 1'b0);

        // Abort during a normalise shift
        cur_m0 = 5'b00011; cur_stuck = 1'b0; cur_ne = 99; add_except = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (norm_en && !norm_load) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) timeouts++;
        #2 clr_n = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (8) @(negedge clk);

        for (int n = 0; n < 70; n++) begin
            run_tx($urandom_range(0, 5) == 0,
                   5'($urandom_range(0, 31)),
                   $urandom_range(0, 5) == 0,
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : 99,
                   $urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        drv_done = 1'b1;
    end

endmodule
